shape_cmd_scheduler: RTL and testbench

//   Shares one shape_processor SFR port between NUM_REQ requesters. Each request is one
//   (shape, operation) command. The block grants requesters round-robin, then programs

---
 rtl/shape_cmd_scheduler.sv | 165 ++++++++++++++++
 tb/tb_shape_cmd_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shape_cmd_scheduler.sv
// Round-robin arbiter that programs the shared shape_processor ctrl_sfr with one
// write plus one readback read per command and reports pass/fail per requester.
module shape_cmd_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_shape,
  input  logic [5*NUM_REQ-1:0] req_operation,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic                 rsp_error,
  output logic                 sp_write,
  output logic [31:0]          sp_write_data,
  output logic                 sp_read,
  input  logic [31:0]          sp_read_data,
  input  logic                 sp_error,
  output logic                 busy,
  output logic [7:0]           err_count
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [7:0]         err_count_q, err_count_d;
  logic [1:0]         shape_q, shape_d;
  logic [4:0]         op_q, op_d;
  logic               sp_write_q, sp_write_d;
  logic [31:0]        sp_write_data_q, sp_write_data_d;
  logic               sp_read_q, sp_read_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_error_q, rsp_error_d;

  logic [1:0]         shape_arr [NUM_REQ];
  logic [4:0]         op_arr    [NUM_REQ];
  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               unused_rd;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign shape_arr[i] = req_shape[2*i +: 2];
    assign op_arr[i]    = req_operation[5*i +: 5];
  end

  // Only the shape and operation fields are compared on readback.
  assign unused_rd = ^{sp_read_data[31:18], sp_read_data[15:5]};

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_onehot = '0;
    if (grant_found) grant_onehot[grant_idx] = 1'b1;
  end

  assign req_ready = (state_q == IDLE && !rst) ? grant_onehot : '0;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    g_d             = g_q;
    wait_cnt_d      = wait_cnt_q;
    err_count_d     = err_count_q;
    shape_d         = shape_q;
    op_d            = op_q;
    sp_write_d      = 1'b0;
    sp_write_data_d = '0;
    sp_read_d       = 1'b0;
    rsp_valid_d     = '0;
    rsp_error_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d         = WRITE;
          g_d             = grant_idx;
          shape_d         = shape_arr[grant_idx];
          op_d            = op_arr[grant_idx];
          sp_write_d      = 1'b1;
          sp_write_data_d = {14'b0, shape_arr[grant_idx], 11'b0, op_arr[grant_idx]};
        end
      end
      WRITE: begin
        state_d   = READ;
        sp_read_d = 1'b1;
      end
      READ: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        // Last WAIT cycle is the one where readback data is valid.
        if (wait_cnt_q == CNT_LAST) begin
          state_d             = RESP;
          rsp_valid_d[g_q]    = 1'b1;
          rsp_error_d         = sp_error | (sp_read_data[17:16] != shape_q)
                                         | (sp_read_data[4:0] != op_q);
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d      = IDLE;
        last_grant_d = g_q;
        if (rsp_error_q && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      last_grant_q    <= IDX_W'(NUM_REQ - 1);
      g_q             <= '0;
      wait_cnt_q      <= '0;
      err_count_q     <= '0;
      sp_write_q      <= 1'b0;
      sp_write_data_q <= '0;
      sp_read_q       <= 1'b0;
      rsp_valid_q     <= '0;
      rsp_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      g_q             <= g_d;
      wait_cnt_q      <= wait_cnt_d;
      err_count_q     <= err_count_d;
      sp_write_q      <= sp_write_d;
      sp_write_data_q <= sp_write_data_d;
      sp_read_q       <= sp_read_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_error_q     <= rsp_error_d;
    end
  end

  always_ff @(posedge clk) begin
    shape_q <= shape_d;
    op_q    <= op_d;
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_error     = rsp_error_q;
  assign sp_write      = sp_write_q;
  assign sp_write_data = sp_write_data_q;
  assign sp_read       = sp_read_q;
  assign busy          = (state_q != IDLE);
  assign err_count     = err_count_q;
endmodule

// File: tb/tb_shape_cmd_scheduler.sv
// Scoreboard bench for shape_cmd_scheduler: directed commands against a small
// shape_processor responder with injectable readback corruption and error flag.
module tb_shape_cmd_scheduler;
  localparam int NUM_REQ      = 4;
  localparam int READ_LATENCY = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [7:0]  req_shape;
  logic [19:0] req_operation;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic        rsp_error;
  logic        sp_write;
  logic [31:0] sp_write_data;
  logic        sp_read;
  logic [31:0] sp_read_data;
  logic        sp_error;
  logic        busy;
  logic [7:0]  err_count;

  logic [31:0] stored;
  logic [31:0] corrupt_mask;
  logic        inject_err;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [4:0]  exp_q[$];

  shape_cmd_scheduler #(.NUM_REQ(NUM_REQ), .READ_LATENCY(READ_LATENCY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_shape(req_shape),
    .req_operation(req_operation), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_error(rsp_error), .sp_write(sp_write), .sp_write_data(sp_write_data),
    .sp_read(sp_read), .sp_read_data(sp_read_data), .sp_error(sp_error),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Processor model: readback one cycle after the read strobe.
  always @(posedge clk) begin
    if (sp_write) stored <= sp_write_data;
    if (sp_read) begin
      sp_read_data <= stored ^ corrupt_mask;
      sp_error     <= inject_err;
    end else begin
      sp_read_data <= 32'h0;
      sp_error     <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  always @(negedge clk) begin : monitor
    logic [4:0] e;
    if (rsp_valid != 4'b0) begin
      if (exp_q.size() == 0) begin
        timeout("rsp_unexpected");
      end else begin
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e[4:1]));
        chk("rsp_error", 32'(rsp_error), 32'(e[0]));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeout("idle_timeout");
  endtask

  // Called at a negedge with the DUT idle; requester i is the only one asking.
  task automatic issue(input int i, input logic [1:0] sh, input logic [4:0] op,
                       input logic exp_err);
    int n = 0;
    req_shape[2*i +: 2]     = sh;
    req_operation[5*i +: 5] = op;
    req_valid[i]            = 1'b1;
    exp_q.push_back({4'(1 << i), exp_err});
    #1;
    while (!req_ready[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) timeout("grant_timeout");
    chk("grant_onehot", 32'(req_ready), 32'(1 << i));
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    wait_idle();
  endtask

  initial begin
    int prev;
    int m;
    rst           = 1'b1;
    req_valid     = 4'hF;
    req_shape     = {2'd3, 2'd2, 2'd1, 2'd0};
    req_operation = {5'h04, 5'h03, 5'h02, 5'h01};
    corrupt_mask  = 32'h0;
    inject_err    = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_error", 32'(rsp_error), 32'h0);
    chk("reset_sp_write", 32'(sp_write), 32'h0);
    chk("reset_sp_read", 32'(sp_read), 32'h0);
    chk("reset_wdata", sp_write_data, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_err_count", 32'(err_count), 32'h0);
    rst = 1'b0;
    #1 chk("first_grant", 32'(req_ready), 32'h1);
    req_valid = 4'b0001;
    exp_q.push_back({4'b0001, 1'b0});
    @(posedge clk);
    #1 req_valid = 4'b0;
    wait_idle();

    // Single command from requester 1 with cycle-exact strobes.
    req_shape[3:2]     = 2'b10;
    req_operation[9:5] = 5'h13;
    req_valid[1]       = 1'b1;
    #1 chk("t0_grant", 32'(req_ready), 32'h2);
    exp_q.push_back({4'b0010, 1'b0});
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t1_sp_write", 32'(sp_write), 32'h1);
    chk("t1_wdata", sp_write_data, 32'h0002_0013);
    chk("t1_no_read", 32'(sp_read), 32'h0);
    @(negedge clk);
    chk("t2_sp_read", 32'(sp_read), 32'h1);
    chk("t2_no_write", 32'(sp_write), 32'h0);
    chk("t2_wdata_zero", sp_write_data, 32'h0);
    @(negedge clk);
    chk("t3_no_rsp", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("t4_rsp", 32'(rsp_valid), 32'h2);
    wait_idle();

    issue(3, 2'b11, 5'h1F, 1'b0);

    // All four held: grants 0,1,2,3,0 spaced one command apart.
    req_shape     = {2'd0, 2'd1, 2'd2, 2'd3};
    req_operation = {5'h0A, 5'h0B, 5'h0C, 5'h0D};
    req_valid     = 4'hF;
    for (int n = 0; n < 5; n++) exp_q.push_back({4'(1 << (n % 4)), 1'b0});
    #1;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      m = 0;
      while (req_ready == 4'b0 && m < 40) begin
        @(negedge clk);
        m++;
      end
      if (req_ready == 4'b0) timeout("rr_timeout");
      chk("rr_grant", 32'(req_ready), 32'(1 << (n % 4)));
      if (n > 0) chk("rr_spacing", 32'(cyc - prev), 32'd5);
      prev = cyc;
      @(posedge clk);
      #1;
      if (n == 4) req_valid = 4'b0;
    end
    wait_idle();

    corrupt_mask = 32'h0000_0001;
    issue(2, 2'b01, 5'h13, 1'b1);
    chk("err_op_mismatch", 32'(err_count), 32'd1);
    corrupt_mask = 32'h0;
    inject_err   = 1'b1;
    issue(0, 2'b10, 5'h07, 1'b1);
    inject_err   = 1'b0;
    chk("err_sp_error", 32'(err_count), 32'd2);
    corrupt_mask = 32'h0001_0000;
    issue(1, 2'b11, 5'h00, 1'b1);
    chk("err_shape_mismatch", 32'(err_count), 32'd3);
    corrupt_mask = 32'hFFFC_FFE0;
    issue(3, 2'b00, 5'h1A, 1'b0);
    chk("ignored_bits", 32'(err_count), 32'd3);
    corrupt_mask = 32'h0;

    // Reset while waiting for readback drops the command.
    inject_err         = 1'b1;
    req_shape[1:0]     = 2'b01;
    req_operation[4:0] = 5'h05;
    req_valid[0]       = 1'b1;
    #1 chk("rw_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst        = 1'b1;
    inject_err = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rw_busy", 32'(busy), 32'h0);
    chk("rw_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rw_err_count", 32'(err_count), 32'h0);
    chk("rw_regrant", 32'(req_ready), 32'h1);
    exp_q.push_back({4'b0001, 1'b0});
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_idle();
    chk("rw_after_err_count", 32'(err_count), 32'h0);

    inject_err = 1'b1;
    for (int k = 0; k < 256; k++) begin
      issue(k % 4, 2'(k), 5'(k), 1'b1);
      if (k == 253) chk("sat_fe", 32'(err_count), 32'hFE);
      if (k == 254) chk("sat_ff", 32'(err_count), 32'hFF);
    end
    inject_err = 1'b0;
    chk("sat_hold", 32'(err_count), 32'hFF);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
